// File: rtl/fifo_ctrl_arb.sv
// Two-requester round-robin write arbiter in front of a 7-entry FIFO, with a
// registered-read consumer port and tracked occupancy.
module fifo_ctrl_arb #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              fifo_rst,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_data_in,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [3:0]        level,
  output logic              almost_full
);

  localparam int unsigned LVL_W = 4;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(7);
  localparam logic [LVL_W-1:0] LVL_AF  = LVL_W'(AF_LEVEL);

  typedef enum logic {IDLE, VALID} state_t;

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   grant_idx;

  // Write arbitration: on contention, serve whoever was not served last.
  always_comb begin
    grant     = (req0 | req1) & ~fifo_full & ~flush & ~rst;
    grant_idx = (req0 & req1) ? ~last_grant : req1;
  end

  assign ack0         = grant & ~grant_idx;
  assign ack1         = grant & grant_idx;
  assign fifo_wr_en   = grant;
  assign fifo_data_in = (grant & grant_idx) ? data1 : data0;
  assign fifo_rst     = rst | flush;

  // Fetch a word whenever the output slot is empty or being consumed.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && !flush && !fifo_empty) begin
      fifo_rd_en = (state == IDLE) ? 1'b1 : m_ready;
    end
  end

  assign m_valid     = (state == VALID) & ~flush & ~rst;
  assign m_data      = fifo_data_out;
  assign almost_full = (level >= LVL_AF);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty) state <= VALID;
        VALID:   if (m_ready && fifo_empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= grant_idx;
    end
  end

  // Occupancy counter; simultaneous write and read cancel out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level <= '0;
    end else if (fifo_wr_en && !fifo_rd_en && level != LVL_MAX) begin
      level <= level + LVL_W'(1);
    end else if (fifo_rd_en && !fifo_wr_en && level != '0) begin
      level <= level - LVL_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Randomized bench for fifo_ctrl_arb: a behavioural FIFO drives the DUT's FIFO
// port and a queue-based system model predicts every output each cycle.
module tb_fifo_ctrl_arb;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned AF_LEVEL = 6;
  localparam int unsigned DEPTH    = 7;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              req0, req1, ack0, ack1;
  logic [DATA_W-1:0] data0, data1;
  logic              fifo_rst, fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data_in, fifo_data_out, m_data;
  logic              m_valid, m_ready, almost_full;
  logic [3:0]        level;

  always #5 clk = ~clk;

  fifo_ctrl_arb #(.DATA_W(DATA_W), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .level(level), .almost_full(almost_full)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Physical FIFO seen by the DUT
  logic [DATA_W-1:0] bq[$];
  logic [DATA_W-1:0] bdout = '0;

  // System model: words accepted but not yet fetched, plus the consumer slot
  logic [DATA_W-1:0] mq[$];
  bit                slot = 1'b0;
  logic [DATA_W-1:0] slot_word = '0;
  bit                last = 1'b1;

  int p_req, p_ready, p_flush, p_rst;
  bit hold_rst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rnd(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic cycle();
    bit g, gi, exp_rd, exp_mv, full_pre;
    bit s_wr, s_rd, s_rst;
    logic [DATA_W-1:0] s_din, exp_din;
    fifo_full     = (bq.size() == DEPTH);
    fifo_empty    = (bq.size() == 0);
    fifo_data_out = bdout;
    @(negedge clk);
    g       = (req0 || req1) && (mq.size() != DEPTH) && !flush && !rst;
    gi      = (req0 && req1) ? !last : req1;
    exp_mv  = slot && !flush && !rst;
    exp_rd  = !rst && !flush && (mq.size() != 0) && (!slot || m_ready);
    exp_din = (g && gi) ? data1 : data0;
    check_eq("ack0", 32'(ack0), 32'(g && !gi));
    check_eq("ack1", 32'(ack1), 32'(g && gi));
    check_eq("fifo_wr_en", 32'(fifo_wr_en), 32'(g));
    check_eq("fifo_data_in", 32'(fifo_data_in), 32'(exp_din));
    check_eq("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check_eq("fifo_rst", 32'(fifo_rst), 32'(rst || flush));
    check_eq("m_valid", 32'(m_valid), 32'(exp_mv));
    check_eq("level", 32'(level), 32'(mq.size()));
    check_eq("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
    if (exp_mv) check_eq("m_data", 32'(m_data), 32'(slot_word));
    s_wr = fifo_wr_en; s_rd = fifo_rd_en; s_rst = fifo_rst; s_din = fifo_data_in;
    @(posedge clk);
    #1;
    if (s_rst) begin
      bq.delete();
    end else begin
      full_pre = (bq.size() == DEPTH);
      if (s_rd && bq.size() > 0) bdout = bq.pop_front();
      if (s_wr && !full_pre) bq.push_back(s_din);
    end
    if (rst || flush) begin
      mq.delete();
      slot = 1'b0;
      if (rst) last = 1'b1;
    end else begin
      if (exp_rd) begin
        slot_word = mq.pop_front();
        slot = 1'b1;
      end else if (slot && m_ready) begin
        slot = 1'b0;
      end
      if (g) begin
        mq.push_back(exp_din);
        last = gi;
      end
    end
    // Requesters hold req and data until acknowledged
    if (!req0 || (g && !gi)) begin req0 = rnd(p_req); data0 = DATA_W'($urandom); end
    if (!req1 || (g && gi))  begin req1 = rnd(p_req); data1 = DATA_W'($urandom); end
    m_ready = rnd(p_ready);
    flush   = rnd(p_flush);
    rst     = hold_rst || rnd(p_rst);
  endtask

  task automatic run(input int n, input int preq, input int pready, input int pflush, input int prst);
    p_req = preq; p_ready = pready; p_flush = pflush; p_rst = prst;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    hold_rst = 1'b1;
    run(3, 0, 0, 0, 0);
    hold_rst = 1'b0;
    run(1, 0, 0, 0, 0);
    #1;
    check_eq("reset_level", 32'(level), 32'd0);
    check_eq("reset_m_valid", 32'(m_valid), 32'd0);

    // Continuous contention with a free-running consumer: strict alternation
    req0 = 1'b1; req1 = 1'b1; m_ready = 1'b1;
    run(40, 100, 100, 0, 0);

    // Fill to full with a stalled consumer
    m_ready = 1'b0;
    run(20, 100, 0, 0, 0);
    #1;
    check_eq("fill_level", 32'(level), 32'd7);
    check_eq("fill_af", 32'(almost_full), 32'd1);
    check_eq("fill_ack", 32'(ack0 | ack1), 32'd0);

    // Drain
    req0 = 1'b0; req1 = 1'b0; m_ready = 1'b1;
    run(15, 0, 100, 0, 0);
    #1;
    check_eq("drain_level", 32'(level), 32'd0);

    // Flush while a word is presented and being accepted
    run(6, 100, 0, 0, 0);
    flush = 1'b1; req0 = 1'b1; m_ready = 1'b1;
    run(1, 0, 100, 0, 0);
    #1;
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_m_valid", 32'(m_valid), 32'd0);

    // Long random mix including flushes and resets
    run(2000, 60, 60, 3, 2);

    // Reset mid-burst, then contention must go to requester 0 first
    run(10, 100, 100, 0, 0);
    hold_rst = 1'b1; rst = 1'b1;
    run(2, 100, 100, 0, 0);
    hold_rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    run(30, 100, 70, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_arb.md
FIFO_CTRL_ARB -- requirements
Module: fifo_ctrl_arb

Interface
REQ-001 Parameter DATA_W, default 8, data width of requester, FIFO and consumer data paths.
REQ-002 Parameter AF_LEVEL, default 6, occupancy at or above which almost_full SHALL assert (range 1..7).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  synchronous active-high reset
  flush  in  1  synchronous FIFO clear command
  req0  in  1  requester 0 write request; held with data0 until ack0
  data0  in  DATA_W  requester 0 write data
  ack0  out  1  requester 0 word accepted this cycle
  req1  in  1  requester 1 write request; held with data1 until ack1
  data1  in  DATA_W  requester 1 write data
  ack1  out  1  requester 1 word accepted this cycle
  fifo_rst  out  1  FIFO reset drive
  fifo_wr_en  out  1  FIFO write enable
  fifo_data_in  out  DATA_W  FIFO write data
  fifo_full  in  1  FIFO full flag
  fifo_rd_en  out  1  FIFO read enable
  fifo_data_out  in  DATA_W  FIFO registered read data; updates the edge after rd_en
  fifo_empty  in  1  FIFO empty flag
  m_valid  out  1  consumer data valid
  m_data  out  DATA_W  consumer data
  m_ready  in  1  consumer ready; transfer when m_valid and m_ready both high
  level  out  4  tracked FIFO occupancy, 0..7
  almost_full  out  1  level >= AF_LEVEL

Function
REQ-005 Write arbitration SHALL be combinational: a grant occurs when (req0 or req1) and !fifo_full and !flush and !rst.
REQ-006 Only req0 high -> grant 0; only req1 high -> grant 1; both high -> grant the requester NOT granted most recently (round-robin).
REQ-007 Register last_grant SHALL update to the granted index on every grant edge and hold otherwise.
REQ-008 On grant i: ack_i=1, fifo_wr_en=1, fifo_data_in=data_i, all in the same cycle; at most one ack per cycle.
REQ-009 No grant: ack0=ack1=0, fifo_wr_en=0; fifo_data_in SHALL equal data0 (don't-care to FIFO).
REQ-010 Read side SHALL be a two-state FSM: IDLE (no word presented) and VALID (fifo_data_out presented).
REQ-011 m_valid = (state==VALID) && !flush; m_data = fifo_data_out at all times.
REQ-012 IDLE: if !fifo_empty and !flush -> fifo_rd_en=1, next state VALID; else fifo_rd_en=0, stay IDLE.
REQ-013 VALID, m_ready=0: fifo_rd_en=0, stay VALID; m_data held stable.
REQ-014 VALID, m_ready=1, !fifo_empty: fifo_rd_en=1, stay VALID (back-to-back, one word per cycle).
REQ-015 VALID, m_ready=1, fifo_empty: fifo_rd_en=0, next state IDLE.
REQ-016 Read latency: word written at edge N with FIFO previously empty and FSM IDLE SHALL appear with m_valid=1 in cycle N+2.
REQ-017 level SHALL increment on fifo_wr_en only, decrement on fifo_rd_en only, hold when both or neither; no wrap (max 7, min 0).
REQ-018 almost_full SHALL be combinational from level.
REQ-019 Flush: fifo_rst=1 that cycle; no grants, no fifo_rd_en, no consumer transfer; next edge: level=0, FSM IDLE; last_grant unchanged.
REQ-020 fifo_rst = rst | flush.

Reset
REQ-021 On rst: FSM=IDLE, level=0, last_grant=1 (req0 wins first contention), fifo_rst=1; ack0, ack1, fifo_wr_en, fifo_rd_en, m_valid all 0 while rst high.
REQ-022 Reset mid-operation SHALL discard any presented or in-flight word; requesters keep req asserted and are served after reset.

Verification
REQ-023 Reset, then req0 and req1 held continuously with fifo never full -> acks alternate 0,1,0,1...; data appears on m_data in that order.
REQ-024 Both requesters write until fifo_full (7 words) with m_ready=0 -> acks stop, level=7, almost_full=1 from level 6; m_data holds first word.
REQ-025 FIFO with 3 words, m_ready=1 constantly -> three consecutive m_valid cycles, then IDLE; level 3->0.
REQ-026 Simultaneous grant and consumer transfer at level 4 -> level stays 4.
REQ-027 flush asserted while VALID with m_ready=1 and req0 high -> no ack0, no transfer, fifo_rst=1; next cycle level=0, m_valid=0.
REQ-028 rst asserted mid-burst -> all outputs per REQ-021; first post-reset contention grants requester 0.
